rotate_right_seq: RTL and testbench
===================================

# rotate_right_seq

Sequential rotate-right engine for the multifunction shifter, the right-direction counterpart of the existing left rotators. It accepts one operand per transaction over a valid/ready handshake and runs a log-stage rotation, one power-of-two stage per clock. It supports a 16-bit and a 32-bit mode and holds the result until the consumer accepts it. It sits between the shifter's operand register and the result mux wherever a registered, fixed-latency right rotate is needed.

## Interface
- No parameters; the datapath is fixed at 32 bits with a 16-bit mode.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand valid.
- in_ready  output  1  engine can accept an operand. Asserted only in IDLE.
- mode32  input  1  1 selects 32-bit rotate, 0 selects 16-bit rotate. Sampled on accept.
- a  input  32  operand. In 16-bit mode only a[15:0] is used.
- amt  input  5  rotate amount. In 16-bit mode only amt[3:0] is used.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- y  output  32  registered result. In 16-bit mode y[31:16] = 0.
- busy  output  1  high when state is not IDLE.

## Operation
- The state machine has three states: IDLE, RUN and DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, latch the following and go to RUN:
    - work = mode32 ? a : {16'h0, a[15:0]}
    - sh = mode32 ? amt : {1'b0, amt[3:0]}
    - m32 = mode32
    - stage = 0
- RUN: each cycle applies stage k = stage.
  - If sh[k] = 1, rotate work right by 2^k within the active width (16 or 32 bits). Otherwise work is unchanged.
  - In 16-bit mode the rotate is confined to work[15:0], and work[31:16] stays 0.
  - Increment stage each cycle. After the last stage go to DONE; the last stage is 3 in 16-bit mode and 4 in 32-bit mode.
  - All stages run even when sh = 0, so latency is fixed.
- DONE:
  - out_valid = 1 and y = work.
  - y and out_valid hold stable until out_ready = 1.
  - On out_ready, go to IDLE. out_valid drops on the next edge.
- The engine never accepts a new operand in the same cycle a result is taken, because in_ready is low in DONE.
- Inputs a, amt and mode32 are don't-care outside the accept cycle. Changing them during RUN or DONE has no effect.
- The result equals combinational rotate-right by amt mod width: 16 in 16-bit mode, 32 in 32-bit mode.

## Timing
- Reset (asynchronous, while rst_n = 0):
  - state = IDLE, work = 0, stage = 0.
  - y = 0, out_valid = 0, busy = 0, in_ready = 1.
- in_ready, busy and out_valid decode directly from the state register, with no combinational path from inputs.
- Accept at rising edge N:
  - 16-bit mode: out_valid is first high after edge N+4.
  - 32-bit mode: out_valid is first high after edge N+5.
- The result is taken at the edge where out_valid & out_ready. in_ready is high after that edge, so the earliest next accept is the following edge.
- Minimum issue interval:
  - 16-bit mode: 6 cycles with out_ready held high.
  - 32-bit mode: 7 cycles with out_ready held high.
- Reset asserted mid-RUN or mid-DONE aborts the operation immediately. No result is produced, and after release the engine is in IDLE with y = 0.
- out_ready while not in DONE is ignored.

## Test plan
- 16-bit mode, a = 0x0000_8001, amt = 1 -> y = 0x0000_C000, out_valid first high 4 cycles after accept.
- 32-bit mode, a = 0x1234_5678, amt = 8 -> y = 0x7812_3456 after 5 cycles. Also a = 0x0000_0001, amt = 31 -> y = 0x0000_0002.
- 16-bit mode, a = 0xFFFF_00F0, amt = 5'b10100 (amt[4] ignored, so rotate by 4) -> y = 0x0000_000F, and y[31:16] = 0.
- amt = 0 in both modes, a = 0xDEAD_BEEF:
  - 32-bit mode -> y = 0xDEAD_BEEF after 5 cycles.
  - 16-bit mode -> y = 0x0000_BEEF after 4 cycles.
- Backpressure: hold out_ready = 0 for 10 cycles in DONE -> y and out_valid stable and in_ready = 0 throughout. Raise out_ready -> IDLE next cycle, and a back-to-back operand is accepted one cycle later.
- Assert rst_n = 0 two cycles into a 32-bit RUN -> outputs go to reset values immediately. After release, in_ready = 1, out_valid stays 0, and a fresh operation completes correctly.

Source files
------------

// File: rtl/rotate_right_seq.sv
// Sequential rotate-right engine: one power-of-two stage per clock,
// 16-bit or 32-bit width, result held until accepted.
module rotate_right_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        mode32,
    input  logic [31:0] a,
    input  logic [4:0]  amt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] work_q, work_d;
    logic [4:0]  sh_q, sh_d;
    logic        m32_q, m32_d;
    logic [2:0]  stage_q, stage_d;

    logic [5:0]  step;
    logic [63:0] dbl32;
    logic [31:0] dbl16;
    logic [31:0] rot;
    logic        last;

    // Rotation done by shifting a doubled copy of the active width.
    always_comb begin
        step  = 6'd1 << stage_q;
        dbl32 = {work_q, work_q} >> step;
        dbl16 = {work_q[15:0], work_q[15:0]} >> step;
        rot   = m32_q ? dbl32[31:0] : {16'h0, dbl16[15:0]};
        last  = m32_q ? (stage_q == 3'd4) : (stage_q == 3'd3);
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        sh_d    = sh_q;
        m32_d   = m32_q;
        stage_d = stage_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = mode32 ? a : {16'h0, a[15:0]};
                    sh_d    = mode32 ? amt : {1'b0, amt[3:0]};
                    m32_d   = mode32;
                    stage_d = 3'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (sh_q[stage_q]) begin
                    work_d = rot;
                end
                stage_d = stage_q + 3'd1;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= 32'h0;
            sh_q    <= 5'h0;
            m32_q   <= 1'b0;
            stage_q <= 3'd0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            sh_q    <= sh_d;
            m32_q   <= m32_d;
            stage_q <= stage_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign y         = work_q;

endmodule

// File: tb/tb_rotate_right_seq.sv
// Self-checking bench for rotate_right_seq: vector table, random
// vectors against a bitwise model, backpressure and reset abort.
module tb_rotate_right_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        mode32;
    logic [31:0] a;
    logic [4:0]  amt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic        busy;

    rotate_right_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode32    (mode32),
        .a         (a),
        .amt       (amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        m;
        logic [31:0] a;
        logic [4:0]  amt;
        logic [31:0] exp;
        int          hold;
    } vec_t;

    vec_t        vecs[8];
    logic [31:0] sbq[$];
    int          n_pass;
    int          n_tot;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tot++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: rotate one bit at a time, amt mod width times.
    function automatic logic [31:0] model(input logic m,
                                          input logic [31:0] av,
                                          input logic [4:0] am);
        logic [31:0] w;
        logic [15:0] h;
        int          n;
        w = av;
        h = av[15:0];
        n = m ? int'(am) : int'(am[3:0]);
        for (int i = 0; i < n; i++) begin
            w = {w[0], w[31:1]};
            h = {h[0], h[15:1]};
        end
        return m ? w : {16'h0, h};
    endfunction

    // Called at a negedge; returns at a negedge after the result is taken.
    task automatic do_op(input logic m, input logic [31:0] av,
                         input logic [4:0] am, input logic [31:0] ey,
                         input int hold);
        int          lat;
        int          wt;
        logic [31:0] yq;
        logic [31:0] exp_y;
        wt = 0;
        while (!in_ready && wt < 20) begin
            @(negedge clk);
            wt++;
        end
        check("in_ready_before_issue", {31'h0, in_ready}, 32'h1);
        in_valid = 1'b1;
        mode32   = m;
        a        = av;
        amt      = am;
        sbq.push_back(ey);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        mode32   = 1'($urandom);
        a        = $urandom;
        amt      = 5'($urandom);
        check("busy_in_run", {31'h0, busy}, 32'h1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            a   = $urandom;
            amt = 5'($urandom);
            lat++;
        end
        check("latency", lat, m ? 32'd5 : 32'd4);
        exp_y = sbq.pop_front();
        check("y_result", y, exp_y);
        yq = y;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (y !== yq || !out_valid || in_ready) begin
                check("hold_y", y, yq);
                check("hold_valid", {31'h0, out_valid}, 32'h1);
                check("hold_in_ready", {31'h0, in_ready}, 32'h0);
            end
        end
        if (hold > 0) begin
            check("hold_end_y", y, exp_y);
            check("hold_end_in_ready", {31'h0, in_ready}, 32'h0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("valid_dropped", {31'h0, out_valid}, 32'h0);
        check("in_ready_after_take", {31'h0, in_ready}, 32'h1);
    endtask

    initial begin
        logic        rm;
        logic [31:0] ra;
        logic [4:0]  ramt;
        int          lat;
        n_pass    = 0;
        n_tot     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        mode32    = 1'b0;
        a         = 32'h0;
        amt       = 5'h0;

        vecs[0] = '{1'b0, 32'h0000_8001, 5'd1,  32'h0000_C000, 0};
        vecs[1] = '{1'b1, 32'h1234_5678, 5'd8,  32'h7812_3456, 10};
        vecs[2] = '{1'b1, 32'h0000_0001, 5'd31, 32'h0000_0002, 0};
        vecs[3] = '{1'b0, 32'hFFFF_00F0, 5'b10100, 32'h0000_000F, 0};
        vecs[4] = '{1'b1, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 0};
        vecs[5] = '{1'b0, 32'hDEAD_BEEF, 5'd0,  32'h0000_BEEF, 3};
        vecs[6] = '{1'b1, 32'h8000_0000, 5'd16, 32'h0000_8000, 0};
        vecs[7] = '{1'b0, 32'h0000_1234, 5'd15, 32'h0000_2468, 0};

        #12;
        check("rst_y", y, 32'h0);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_in_ready", {31'h0, in_ready}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_ignores_out_ready", {31'h0, in_ready}, 32'h1);

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].m, vecs[i].a, vecs[i].amt, vecs[i].exp,
                  vecs[i].hold);
        end

        for (int i = 0; i < 12; i++) begin
            rm   = 1'($urandom);
            ra   = $urandom;
            ramt = 5'($urandom);
            do_op(rm, ra, ramt, model(rm, ra, ramt), 0);
        end

        // Abort a 32-bit operation two cycles into RUN.
        in_valid = 1'b1;
        mode32   = 1'b1;
        a        = 32'hCAFE_F00D;
        amt      = 5'd3;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_y", y, 32'h0);
        check("abort_out_valid", {31'h0, out_valid}, 32'h0);
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_in_ready", {31'h0, in_ready}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) lat++;
        end
        check("abort_no_result", lat, 32'd0);
        check("abort_in_ready_idle", {31'h0, in_ready}, 32'h1);
        do_op(1'b1, 32'hCAFE_F00D, 5'd4, 32'hDCAF_EF00, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
